karatsuba_mult_seq: RTL and testbench
=====================================

KARATSUBA_MULT_SEQ -- requirements
Module: karatsuba_mult_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width (even, >=4).
REQ-002 The block SHALL have parameter TAG_W, default 4, width of the pass-through transaction tag.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  operand transfer request.
REQ-006 The block SHALL have port in_ready  output  1  block can accept operands.
REQ-007 The block SHALL have ports a, b  input  WIDTH  multiplicands.
REQ-008 The block SHALL have port signed_mode  input  1  1: a, b, product two's-complement; 0: unsigned.
REQ-009 The block SHALL have port in_tag  input  TAG_W  transaction identifier.
REQ-010 The block SHALL have port out_valid  output  1  product available.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts product.
REQ-012 The block SHALL have port ab  output  2*WIDTH  full-width product.
REQ-013 The block SHALL have port out_tag  output  TAG_W  in_tag of the transaction producing ab.

Function
REQ-014 The block SHALL use FSM states IDLE, Z0, Z2, Z1, CMB, OUT.
REQ-015 The block SHALL drive in_ready=1 only in IDLE; a transfer occurs on an edge with in_valid&&in_ready.
REQ-016 On transfer it SHALL register |a|, |b| (two's-complement magnitude if signed_mode and MSB=1, else raw), neg=signed_mode&&(a[MSB]^b[MSB]) and in_tag, then go to Z0.
REQ-017 With H=WIDTH/2 and aL/aH, bL/bH the low/high H bits of the magnitudes, the block SHALL compute z0=aL*bL in Z0, z2=aH*bH in Z2, and z1=(aL+aH)*(bL+bH)-z2-z0 in Z1.
REQ-018 All three products SHALL use one time-shared (H+1)x(H+1) unsigned multiplier; z1 sums SHALL keep their H+1-bit carry.
REQ-019 In CMB it SHALL form P=(z2<<2H)+(z1<<H)+z0 at 2*WIDTH bits, register ab=neg?-P:P, and go to OUT.
REQ-020 Latency: transfer at edge k SHALL give out_valid=1 after edge k+4.
REQ-021 In OUT, out_valid=1; ab and out_tag SHALL stay stable until an edge with out_ready=1, then the FSM returns to IDLE.
REQ-022 out_ready asserted before out_valid SHALL have no effect; in_valid outside IDLE SHALL be ignored and operands not sampled.
REQ-023 Signed -2^(WIDTH-1) magnitude SHALL be 2^(WIDTH-1) unsigned; (-2^(W-1))^2 SHALL yield +2^(2W-2) exactly.
REQ-024 Zero operands or negative-times-zero SHALL yield ab=0 (no negative zero artefact).
REQ-025 The sustained rate SHALL be one transaction per 6 cycles with out_ready held at 1.

Reset
REQ-026 On reset, asynchronously: state=IDLE, out_valid=0, in_ready=1 after release, ab=0, out_tag=0, internal registers cleared.
REQ-027 Reset during any non-IDLE state SHALL abort the transaction with no out_valid pulse for it.

Structure
REQ-028 Package karatsuba_pkg SHALL hold the FSM state enum and split-width helper constants.
REQ-029 The block SHALL instantiate one sub-module karatsuba_submul, a combinational unsigned (H+1)x(H+1) multiplier with 2H+2-bit output.

Verification
REQ-030 Unsigned 123*456, tag 3 -> ab=0x0000DB18 (56088), out_tag=3, out_valid 4 cycles after transfer.
REQ-031 Signed 123*(-456) -> ab=0xFFFF24E8; signed 0xFFFF*0xFFFF -> ab=0x00000001.
REQ-032 Unsigned 0xFFFF*0xFFFF -> 0xFFFE0001; signed 0x8000*0x8000 -> 0x40000000; signed 0x8000*0 -> 0.
REQ-033 out_ready low 10 cycles after out_valid -> ab, out_tag, out_valid stable, in_ready=0, new in_valid ignored; release -> IDLE next edge.
REQ-034 Reset pulsed in Z2 -> out_valid never asserts for that transaction; next transaction 7*9 -> 63.
REQ-035 Random signed/unsigned sweep, WIDTH=16 and WIDTH=32, against a*b reference -> zero mismatches.

Source files
------------

// File: rtl/karatsuba_pkg.sv
// Shared definitions for the sequential Karatsuba multiplier.
//   kmul_state_e : controller states, in the order a transaction visits them
//   half_w()     : low/high split width H of a WIDTH-bit operand
//   sub_w()      : operand width of the shared sub-multiplier (H+1, room for the
//                  carry out of aL+aH / bL+bH)
package karatsuba_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        Z0   = 3'd1,
        Z2   = 3'd2,
        Z1   = 3'd3,
        CMB  = 3'd4,
        OUT  = 3'd5
    } kmul_state_e;

    localparam int MIN_WIDTH = 4;

    function automatic int half_w(input int w);
        return w / 2;
    endfunction

    function automatic int sub_w(input int w);
        return (w / 2) + 1;
    endfunction

endpackage

// File: rtl/karatsuba_submul.sv
// Combinational unsigned (H+1)x(H+1) multiplier, time-shared by the controller
// for the three Karatsuba partial products.
//   x_i, y_i : unsigned operands, H+1 bits
//   p_o      : full product, 2H+2 bits
module karatsuba_submul #(
    parameter int H = 8
) (
    input  logic [H:0]     x_i,
    input  logic [H:0]     y_i,
    output logic [2*H+1:0] p_o
);

    assign p_o = {{(H+1){1'b0}}, x_i} * {{(H+1){1'b0}}, y_i};

endmodule

// File: rtl/karatsuba_mult_seq.sv
// Sequential WIDTH x WIDTH multiplier (signed or unsigned) using one level of
// Karatsuba decomposition over a single shared (H+1)x(H+1) multiplier.
// One transaction every 6 cycles; product valid 4 edges after the transfer.
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid/in_ready     : operand handshake (ready only when idle)
//   a, b, signed_mode     : operands and two's-complement select
//   in_tag / out_tag      : pass-through transaction identifier
//   out_valid/out_ready   : product handshake; ab holds the 2*WIDTH product
module karatsuba_mult_seq
    import karatsuba_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] ab,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int H  = half_w(WIDTH);
    localparam int PW = 2 * WIDTH;

    kmul_state_e state_q, state_d;

    logic [WIDTH-1:0] mag_a_q, mag_b_q;
    logic [WIDTH-1:0] mag_a_d, mag_b_d;
    logic             neg_q;
    logic [TAG_W-1:0] tag_q, out_tag_q;
    logic [2*H-1:0]   z0_q, z2_q;
    logic [2*H+1:0]   z1_q, z1_d;
    logic [PW-1:0]    ab_q, ab_d, p_full;

    logic [H:0]       mul_x, mul_y;
    logic [2*H+1:0]   mul_p;
    logic [H:0]       sum_a, sum_b;

    // Magnitude of a negative two's-complement operand; -2^(W-1) maps to
    // 2^(W-1), which is still representable as an unsigned WIDTH-bit value.
    assign mag_a_d = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign mag_b_d = (signed_mode && b[WIDTH-1]) ? -b : b;

    assign sum_a = {1'b0, mag_a_q[H-1:0]} + {1'b0, mag_a_q[WIDTH-1:H]};
    assign sum_b = {1'b0, mag_b_q[H-1:0]} + {1'b0, mag_b_q[WIDTH-1:H]};

    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state_q)
            Z0: begin
                mul_x = {1'b0, mag_a_q[H-1:0]};
                mul_y = {1'b0, mag_b_q[H-1:0]};
            end
            Z2: begin
                mul_x = {1'b0, mag_a_q[WIDTH-1:H]};
                mul_y = {1'b0, mag_b_q[WIDTH-1:H]};
            end
            Z1: begin
                mul_x = sum_a;
                mul_y = sum_b;
            end
            default: ;
        endcase
    end

    karatsuba_submul #(.H(H)) u_submul (
        .x_i (mul_x),
        .y_i (mul_y),
        .p_o (mul_p)
    );

    // z1 is always non-negative and below 2^(2H+1), so the 2H+2-bit wrap is exact.
    assign z1_d   = mul_p - {2'b00, z2_q} - {2'b00, z0_q};
    assign p_full = {z2_q, {(2*H){1'b0}}} + (PW'(z1_q) << H) + PW'(z0_q);
    assign ab_d   = neg_q ? -p_full : p_full;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = Z0;
            end
            Z0:  state_d = Z2;
            Z2:  state_d = Z1;
            Z1:  state_d = CMB;
            CMB: state_d = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            neg_q     <= 1'b0;
            tag_q     <= '0;
            z0_q      <= '0;
            z2_q      <= '0;
            z1_q      <= '0;
            ab_q      <= '0;
            out_tag_q <= '0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                mag_a_q <= mag_a_d;
                mag_b_q <= mag_b_d;
                neg_q   <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
                tag_q   <= in_tag;
            end
            if (state_q == Z0) z0_q <= mul_p[2*H-1:0];
            if (state_q == Z2) z2_q <= mul_p[2*H-1:0];
            if (state_q == Z1) z1_q <= z1_d;
            if (state_q == CMB) begin
                ab_q      <= ab_d;
                out_tag_q <= tag_q;
            end
        end
    end

    assign ab      = ab_q;
    assign out_tag = out_tag_q;

endmodule

// File: tb/tb_karatsuba_mult_seq.sv
module tb_karatsuba_mult_seq;

    typedef struct {
        logic [63:0] ab;
        logic [3:0]  tag;
    } sb_t;

    logic clk, reset;

    logic        in_valid16, in_ready16, signed16, out_valid16, out_ready16;
    logic [15:0] a16, b16;
    logic [3:0]  in_tag16, out_tag16;
    logic [31:0] ab16;

    logic        in_valid32, in_ready32, signed32, out_valid32, out_ready32;
    logic [31:0] a32, b32;
    logic [3:0]  in_tag32, out_tag32;
    logic [63:0] ab32;

    sb_t q16[$];
    sb_t q32[$];

    int n_pass, n_total;
    int cyc, last_xfer;

    karatsuba_mult_seq #(.WIDTH(16), .TAG_W(4)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .signed_mode(signed16), .in_tag(in_tag16),
        .out_valid(out_valid16), .out_ready(out_ready16), .ab(ab16), .out_tag(out_tag16)
    );

    karatsuba_mult_seq #(.WIDTH(32), .TAG_W(4)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .signed_mode(signed32), .in_tag(in_tag32),
        .out_valid(out_valid32), .out_ready(out_ready32), .ab(ab32), .out_tag(out_tag32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: event did not occur within its bound", name);
    endtask

    // Reference product: interpret operands as w-bit signed/unsigned integers,
    // multiply with 64-bit integer arithmetic, keep the low 2w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x,
                                            input logic [31:0] y, input bit s);
        longint sx, sy;
        logic [63:0] r;
        logic [31:0] m;
        m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        x  = x & m;
        y  = y & m;
        sx = longint'({32'b0, x});
        sy = longint'({32'b0, y});
        if (s && x[w-1]) sx = sx - (longint'(1) << w);
        if (s && y[w-1]) sy = sy - (longint'(1) << w);
        r = 64'(sx * sy);
        if (w < 32) r = r & ((64'd1 << (2 * w)) - 64'd1);
        return r;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'd1 << (w - 1);
            3: v = (32'd1 << (w - 1)) - 32'd1;
            default: v = $urandom;
        endcase
        if (w < 32) v = v & ((32'd1 << w) - 32'd1);
        return v;
    endfunction

    // Scoreboard monitors: compare on every accepted product.
    always @(negedge clk) begin
        if (!reset && out_valid16 && out_ready16) begin
            if (q16.size() == 0) fail_now("out16_unexpected");
            else begin
                sb_t e;
                e = q16.pop_front();
                chk("ab16", {32'b0, ab16}, e.ab);
                chk("tag16", {60'b0, out_tag16}, {60'b0, e.tag});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid32 && out_ready32) begin
            if (q32.size() == 0) fail_now("out32_unexpected");
            else begin
                sb_t e;
                e = q32.pop_front();
                chk("ab32", ab32, e.ab);
                chk("tag32", {60'b0, out_tag32}, {60'b0, e.tag});
            end
        end
    end

    task automatic send16(input logic [15:0] x, input logic [15:0] y, input bit s,
                          input logic [3:0] t, input logic [63:0] e,
                          input bit push, input bit lat);
        int n;
        sb_t item;
        n = 0;
        while (!in_ready16 && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready16) fail_now("in_ready16_wait");
        a16 = x; b16 = y; signed16 = s; in_tag16 = t; in_valid16 = 1'b1;
        if (push) begin item.ab = e; item.tag = t; q16.push_back(item); end
        @(posedge clk); #1;
        last_xfer = cyc;
        in_valid16 = 1'b0;
        if (lat) begin
            n = 0;
            while (!out_valid16 && n < 20) begin @(posedge clk); #1; n++; end
            chk("latency16", 64'(n), 64'd4);
        end
    endtask

    task automatic send32(input logic [31:0] x, input logic [31:0] y, input bit s,
                          input logic [3:0] t);
        int n;
        sb_t item;
        n = 0;
        while (!in_ready32 && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready32) fail_now("in_ready32_wait");
        a32 = x; b32 = y; signed32 = s; in_tag32 = t; in_valid32 = 1'b1;
        item.ab = ref_mul(32, x, y, s); item.tag = t; q32.push_back(item);
        @(posedge clk); #1;
        in_valid32 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        logic [15:0] ra, rb;
        bit rs;
        n_pass = 0; n_total = 0; last_xfer = 0;
        reset = 1'b1;
        in_valid16 = 0; a16 = 0; b16 = 0; signed16 = 0; in_tag16 = 0; out_ready16 = 1;
        in_valid32 = 0; a32 = 0; b32 = 0; signed32 = 0; in_tag32 = 0; out_ready32 = 1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready16", {63'b0, in_ready16}, 64'd1);
        chk("rst_out_valid16", {63'b0, out_valid16}, 64'd0);
        chk("rst_ab16", {32'b0, ab16}, 64'd0);
        chk("rst_tag16", {60'b0, out_tag16}, 64'd0);
        chk("rst_in_ready32", {63'b0, in_ready32}, 64'd1);

        // Directed vectors with spec-given products
        send16(16'd123,   16'd456,   0, 4'd3, 64'h0000_DB18, 1, 1);
        send16(16'd123,   16'hFE38,  1, 4'd4, 64'hFFFF_24E8, 1, 1);
        send16(16'hFFFF,  16'hFFFF,  1, 4'd5, 64'h0000_0001, 1, 0);
        send16(16'hFFFF,  16'hFFFF,  0, 4'd6, 64'hFFFE_0001, 1, 0);
        send16(16'h8000,  16'h8000,  1, 4'd7, 64'h4000_0000, 1, 1);
        send16(16'h8000,  16'h0000,  1, 4'd8, 64'h0000_0000, 1, 0);
        send16(16'h0000,  16'hFFFF,  1, 4'd9, 64'h0000_0000, 1, 0);

        // Back-to-back throughput with out_ready held high
        send16(16'd1, 16'd1, 0, 4'd0, 64'd1, 1, 0);
        prev = last_xfer;
        for (int i = 0; i < 4; i++) begin
            ra = pick(16); rb = pick(16); rs = 1'($urandom_range(0, 1));
            send16(ra, rb, rs, 4'(i), ref_mul(16, {16'b0, ra}, {16'b0, rb}, rs), 1, 0);
            chk("xfer_spacing", 64'(last_xfer - prev), 64'd6);
            prev = last_xfer;
        end

        // Backpressure: product held 10 cycles, new requests ignored
        repeat (8) @(posedge clk);
        #1 out_ready16 = 1'b0;
        send16(16'h1234, 16'h5678, 0, 4'hA, ref_mul(16, 32'h1234, 32'h5678, 0), 1, 1);
        for (int i = 0; i < 10; i++) begin
            in_valid16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); in_tag16 = 4'hF;
            @(negedge clk);
            chk("stall_valid", {63'b0, out_valid16}, 64'd1);
            chk("stall_ab", {32'b0, ab16}, ref_mul(16, 32'h1234, 32'h5678, 0));
            chk("stall_tag", {60'b0, out_tag16}, 64'hA);
            chk("stall_in_ready", {63'b0, in_ready16}, 64'd0);
            @(posedge clk); #1;
        end
        in_valid16 = 1'b0;
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        chk("release_idle", {63'b0, in_ready16}, 64'd1);
        chk("release_valid", {63'b0, out_valid16}, 64'd0);

        // Reset in Z2 aborts the transaction
        send16(16'hAAAA, 16'h5555, 0, 4'h2, 64'd0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        chk("abort_ab_cleared", {32'b0, ab16}, 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_valid", {63'b0, out_valid16}, 64'd0);
        end
        @(posedge clk); #1;
        send16(16'd7, 16'd9, 0, 4'h1, 64'd63, 1, 1);

        // Random sweeps
        for (int i = 0; i < 200; i++) begin
            ra = pick(16); rb = pick(16); rs = 1'($urandom_range(0, 1));
            send16(ra, rb, rs, 4'($urandom), ref_mul(16, {16'b0, ra}, {16'b0, rb}, rs), 1, 0);
        end
        for (int i = 0; i < 150; i++) begin
            send32(pick(32), pick(32), 1'($urandom_range(0, 1)), 4'($urandom));
        end

        for (int i = 0; i < 50 && (q16.size() != 0 || q32.size() != 0); i++) @(posedge clk);
        @(negedge clk);
        chk("q16_drained", 64'(q16.size()), 64'd0);
        chk("q32_drained", 64'(q32.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
